// File: rtl/mtime_timer.sv
// CLINT machine timer: 64-bit mtime counter and mtimecmp register on a 32-bit bus.
// Optional mtime prescaler is enabled by defining MTIME_PRESCALE_EN.
module mtime_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mtime_addr_i,
    input  logic        mtime_write_valid_i,
    input  logic [31:0] mtime_wdata_i,
    output logic [31:0] mtime_rdata_o,
    output logic        mtime_ge_mtime_o
);

    localparam logic [31:0] ADDR_CMP_LO = BASE_ADDR + 32'h0000_4000;
    localparam logic [31:0] ADDR_CMP_HI = BASE_ADDR + 32'h0000_4004;
    localparam logic [31:0] ADDR_MT_LO  = BASE_ADDR + 32'h0000_BFF8;
    localparam logic [31:0] ADDR_MT_HI  = BASE_ADDR + 32'h0000_BFFC;

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("mtime_timer: TICK_DIV must be >= 1");
    end

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi;
    logic        tick;

    assign wr_mt_lo  = mtime_write_valid_i && (mtime_addr_i == ADDR_MT_LO);
    assign wr_mt_hi  = mtime_write_valid_i && (mtime_addr_i == ADDR_MT_HI);
    assign wr_cmp_lo = mtime_write_valid_i && (mtime_addr_i == ADDR_CMP_LO);
    assign wr_cmp_hi = mtime_write_valid_i && (mtime_addr_i == ADDR_CMP_HI);

`ifdef MTIME_PRESCALE_EN
    localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    // An mtime write restarts the prescale period so the written value is held a full period.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = div_q + DIV_W'(1);
        if (wr_mt_lo || wr_mt_hi || tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A write to either mtime half suppresses the increment for the whole counter.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mt_lo) begin
            mtime_d[31:0] = mtime_wdata_i;
        end else if (wr_mt_hi) begin
            mtime_d[63:32] = mtime_wdata_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = mtime_wdata_i;
        end else if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = mtime_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    always_comb begin
        mtime_rdata_o = 32'h0;
        if (mtime_addr_i == ADDR_CMP_LO) begin
            mtime_rdata_o = mtimecmp_q[31:0];
        end else if (mtime_addr_i == ADDR_CMP_HI) begin
            mtime_rdata_o = mtimecmp_q[63:32];
        end else if (mtime_addr_i == ADDR_MT_LO) begin
            mtime_rdata_o = mtime_q[31:0];
        end else if (mtime_addr_i == ADDR_MT_HI) begin
            mtime_rdata_o = mtime_q[63:32];
        end
    end

    assign mtime_ge_mtime_o = (mtime_q >= mtimecmp_q);

endmodule

// File: tb/tb_mtime_timer.sv
// Scoreboard bench for mtime_timer: directed checks plus random traffic against a register-level model.
module tb_mtime_timer;

    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam logic [31:0] CMPLO = BASE + 32'h4000;
    localparam logic [31:0] CMPHI = BASE + 32'h4004;
    localparam logic [31:0] MTLO  = BASE + 32'hBFF8;
    localparam logic [31:0] MTHI  = BASE + 32'hBFFC;
`ifdef MTIME_PRESCALE_EN
    localparam int unsigned DIV = 4;
`else
    localparam int unsigned DIV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ge;

    mtime_timer #(.BASE_ADDR(BASE), .TICK_DIV(DIV)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mtime_addr_i        (addr),
        .mtime_write_valid_i (we),
        .mtime_wdata_i       (wdata),
        .mtime_rdata_o       (rdata),
        .mtime_ge_mtime_o    (ge)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        ge;
        string       name;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural register values and prescale phase.
    logic [63:0] m_time = 64'h0;
    logic [63:0] m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    int unsigned m_pc   = 0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == CMPLO) return m_cmp[31:0];
        if (a == CMPHI) return m_cmp[63:32];
        if (a == MTLO)  return m_time[31:0];
        if (a == MTHI)  return m_time[63:32];
        return 32'h0;
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit tick;
        tick = (m_pc == DIV - 1);
        if (r) begin
            m_time = 64'h0;
            m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_pc   = 0;
        end else begin
            if (w && a == MTLO)      m_time[31:0]  = d;
            else if (w && a == MTHI) m_time[63:32] = d;
            else if (tick)           m_time        = m_time + 64'd1;
            if (w && (a == MTLO || a == MTHI)) m_pc = 0;
            else                               m_pc = (m_pc + 1) % DIV;
            if (w && a == CMPLO) m_cmp[31:0]  = d;
            if (w && a == CMPHI) m_cmp[63:32] = d;
        end
    endtask

    // mode 0: no check, 1: expect model value, 2: expect the given constants
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int mode, input logic [31:0] crd, input logic cge, input string nm);
        exp_t e;
        rst = r; we = w; addr = a; wdata = d;
        if (mode == 1) begin
            e.rd = m_read(a); e.ge = (m_time >= m_cmp); e.name = nm;
            sb.push_back(e);
        end else if (mode == 2) begin
            e.rd = crd; e.ge = cge; e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, MTLO, 32'h0, 1, 32'h0, 1'b0, "idle");
    endtask

    task automatic chk(input logic [31:0] a, input logic [31:0] rd, input logic g, input string nm);
        step(1'b0, 1'b0, a, 32'h0, 2, rd, g, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, a, d, 1, 32'h0, 1'b0, "write");
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, MTLO, 32'h0, 0, 32'h0, 1'b0, "reset");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (rdata !== e.rd || ge !== e.ge) begin
                    n_fail++;
                    $display("FAIL %s: got rdata=%h ge=%b, expected rdata=%h ge=%b",
                             e.name, rdata, ge, e.rd, e.ge);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] a, d;
        int sel;
        do_reset(2);
`ifdef MTIME_PRESCALE_EN
        idle(12);
        chk(MTLO, 32'd3, 1'b0, "presc_after_reset");
        wr(MTLO, 32'd100);
        idle(3);
        chk(MTLO, 32'd100, 1'b0, "presc_hold");
        chk(MTLO, 32'd101, 1'b0, "presc_tick");
`else
        idle(10);
        chk(MTLO, 32'd10, 1'b0, "count_lo");
        chk(MTHI, 32'd0, 1'b0, "count_hi");
        chk(CMPLO, 32'hFFFF_FFFF, 1'b0, "cmp_reset");
        wr(MTLO, 32'hFFFF_FFFE);
        wr(MTHI, 32'h0);
        idle(2);
        chk(MTLO, 32'h0, 1'b0, "carry_lo");
        chk(MTHI, 32'h1, 1'b0, "carry_hi");

        do_reset(1);
        wr(CMPHI, 32'h0);
        wr(CMPLO, 32'd20);
        idle(17);
        chk(MTLO, 32'd19, 1'b0, "ge_below");
        chk(MTLO, 32'd20, 1'b1, "ge_rise");
        chk(MTLO, 32'd21, 1'b1, "ge_level");
        step(1'b0, 1'b1, CMPLO, 32'hFFFF_FF00, 2, 32'd20, 1'b1, "ge_before_raise");
        chk(CMPLO, 32'hFFFF_FF00, 1'b0, "ge_drop");

        wr(BASE, 32'h1234);
        wr(BASE + 32'h4002, 32'h1234);
        chk(BASE, 32'h0, 1'b0, "unmapped_base");
        chk(BASE + 32'h4002, 32'h0, 1'b0, "unmapped_misaligned");
        chk(CMPLO, 32'hFFFF_FF00, 1'b0, "unmapped_no_effect");

        step(1'b1, 1'b1, MTLO, 32'h55, 1, 32'h0, 1'b0, "rst_with_write");
        chk(MTLO, 32'h0, 1'b0, "rst_wins_mtime");
        chk(CMPHI, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
`endif
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: a = CMPLO;
                1: a = CMPHI;
                2: a = MTLO;
                3: a = MTHI;
                4: a = BASE + ($urandom_range(0, 16'hFFFF) & 32'hFFFC);
                5: a = MTLO + $urandom_range(1, 3);
                6: a = $urandom;
                default: a = CMPLO + $urandom_range(1, 3);
            endcase
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 64);
                1: d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: d = $urandom;
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, a, d, 1, 32'h0, 1'b0, "random");
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
